// File: rtl/p_int_mac.sv
// p_int_mac: pipelined integer multiply-accumulate that returns one dot product per in_last
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   in_valid/in_ready   - operand pair handshake (in1, in2, in_last)
//   out_valid/out_ready - result handshake (out, ovf held stable while waiting)
`ifndef Enable
`define Enable 1'b1
`endif
`ifndef Disable
`define Disable 1'b0
`endif
`ifndef DEF_DCONF
`define DEF_DCONF '{sign: 1'b1, prec: 16'd16}
`endif

package p_int_mac_pkg;
   typedef struct packed {
      logic        sign;
      logic [15:0] prec;
   } dconf_t;
endpackage

module p_int_mac
   import p_int_mac_pkg::*;
#(
   parameter dconf_t      I1_CONF = `DEF_DCONF,
   parameter dconf_t      I2_CONF = `DEF_DCONF,
   parameter dconf_t      O_CONF  = `DEF_DCONF,
   parameter int unsigned ACC_EXT = 8,
   parameter bit          SAT     = `Enable
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [I1_CONF.prec-1:0] in1,
   input  logic [I2_CONF.prec-1:0] in2,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [O_CONF.prec-1:0]  out,
   output logic                    ovf
);
   localparam int I1_PREC  = int'(I1_CONF.prec);
   localparam int I2_PREC  = int'(I2_CONF.prec);
   localparam int O_PREC   = int'(O_CONF.prec);
   localparam bit E_SIGN   = I1_CONF.sign | I2_CONF.sign;
   localparam int E_PREC   = I1_PREC + I2_PREC;
   localparam int ACC_PREC = E_PREC + int'(ACC_EXT);

   typedef enum logic {ACC, DONE} state_t;

   state_t              state_q, state_d;
   logic                p_valid_q, p_last_q;
   logic [E_PREC-1:0]   p_prod_q;
   logic [ACC_PREC-1:0] acc_q, acc_d;
   logic                acc_ovf_q, acc_ovf_d, first_q, first_d;
   logic [E_PREC-1:0]   op1, op2;
   logic [ACC_PREC:0]   acc_x, prod_x, sum;
   logic                accept, hs, sum_ovf, res_ovf;
   logic [O_PREC-1:0]   res;

   // Operands widened to the product width; modular multiply then yields the exact
   // product for every signedness mix (mixed: unsigned side is zero-extended).
   assign op1 = {{I2_PREC{I1_CONF.sign & in1[I1_PREC-1]}}, in1};
   assign op2 = {{I1_PREC{I2_CONF.sign & in2[I2_PREC-1]}}, in2};

   assign in_ready  = (state_q == ACC) & ~(p_valid_q & p_last_q);
   assign out_valid = (state_q == DONE);
   assign accept    = in_valid & in_ready;
   assign hs        = out_valid & out_ready;

   // One guard bit above the accumulator exposes overflow of each add.
   assign acc_x   = {E_SIGN & acc_q[ACC_PREC-1], acc_q};
   assign prod_x  = {{(ACC_EXT + 1){E_SIGN & p_prod_q[E_PREC-1]}}, p_prod_q};
   assign sum     = (first_q ? '0 : acc_x) + prod_x;
   assign sum_ovf = E_SIGN ? sum[ACC_PREC] ^ sum[ACC_PREC-1] : sum[ACC_PREC];

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      acc_ovf_d = acc_ovf_q;
      first_d   = first_q | hs;
      if (p_valid_q) begin
         acc_d     = sum[ACC_PREC-1:0];
         acc_ovf_d = (~first_q & acc_ovf_q) | sum_ovf;
         first_d   = 1'b0;
         if (p_last_q) state_d = DONE;
      end
      if (hs) state_d = ACC;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ACC;
         p_valid_q <= 1'b0;
         p_last_q  <= 1'b0;
         p_prod_q  <= '0;
         acc_q     <= '0;
         acc_ovf_q <= 1'b0;
         first_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         p_valid_q <= accept;
         acc_q     <= acc_d;
         acc_ovf_q <= acc_ovf_d;
         first_q   <= first_d;
         if (accept) begin
            p_last_q <= in_last;
            p_prod_q <= op1 * op2;
         end
      end
   end

   generate
      if (O_PREC >= ACC_PREC) begin : g_wide
         assign res     = O_PREC'({{O_PREC{acc_x[ACC_PREC]}}, acc_x});
         assign res_ovf = acc_ovf_q;
      end else begin : g_narrow
         localparam int OSH = O_CONF.sign ? O_PREC - 1 : O_PREC;
         logic [ACC_PREC:0] omax, omin;
         logic              hi, lo;
         assign omax    = {1'b0, {ACC_PREC{1'b1}}} >> (ACC_PREC - OSH);
         assign omin    = O_CONF.sign ? ~omax : '0;
         assign hi      = $signed(acc_x) > $signed(omax);
         assign lo      = $signed(acc_x) < $signed(omin);
         assign res     = (SAT && hi) ? omax[O_PREC-1:0] :
                          (SAT && lo) ? omin[O_PREC-1:0] : acc_q[O_PREC-1:0];
         assign res_ovf = acc_ovf_q | hi | lo;
      end
   endgenerate

   assign out = out_valid ? res : '0;
   assign ovf = out_valid & res_ovf;
endmodule

// File: tb/tb_p_int_mac.sv
// tb_p_int_mac: scoreboard bench driving five p_int_mac configurations with shared stimulus
module tb_p_int_mac;
   import p_int_mac_pkg::*;

   localparam dconf_t S8  = '{sign: 1'b1, prec: 16'd8};
   localparam dconf_t U8  = '{sign: 1'b0, prec: 16'd8};
   localparam dconf_t S16 = '{sign: 1'b1, prec: 16'd16};
   localparam dconf_t U24 = '{sign: 1'b0, prec: 16'd24};

   typedef struct packed {
      logic [4:0][63:0] o;
      logic [4:0]       f;
      int               cyc;
   } exp_t;

   logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
   logic [7:0]  in1 = '0, in2 = '0;
   logic [4:0]  ir, ov, of;
   logic [15:0] o_a, o_d;
   logic [7:0]  o_b, o_c;
   logic [23:0] o_e;
   int          cyc = 0, n_pass = 0, n_tot = 0, phase = 0;
   logic [7:0]  qa[$], qb[$];
   exp_t        sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   p_int_mac #(.I1_CONF(S8), .I2_CONF(S8), .O_CONF(S16), .ACC_EXT(4), .SAT(1'b1)) u_a (
      .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(ir[0]), .in1(in1), .in2(in2),
      .in_last(in_last), .out_valid(ov[0]), .out_ready(out_ready), .out(o_a), .ovf(of[0]));
   p_int_mac #(.I1_CONF(S8), .I2_CONF(S8), .O_CONF(S8), .ACC_EXT(4), .SAT(1'b1)) u_b (
      .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(ir[1]), .in1(in1), .in2(in2),
      .in_last(in_last), .out_valid(ov[1]), .out_ready(out_ready), .out(o_b), .ovf(of[1]));
   p_int_mac #(.I1_CONF(S8), .I2_CONF(S8), .O_CONF(S8), .ACC_EXT(4), .SAT(1'b0)) u_c (
      .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(ir[2]), .in1(in1), .in2(in2),
      .in_last(in_last), .out_valid(ov[2]), .out_ready(out_ready), .out(o_c), .ovf(of[2]));
   p_int_mac #(.I1_CONF(U8), .I2_CONF(S8), .O_CONF(S16), .ACC_EXT(4), .SAT(1'b1)) u_d (
      .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(ir[3]), .in1(in1), .in2(in2),
      .in_last(in_last), .out_valid(ov[3]), .out_ready(out_ready), .out(o_d), .ovf(of[3]));
   p_int_mac #(.I1_CONF(U8), .I2_CONF(U8), .O_CONF(U24), .ACC_EXT(4), .SAT(1'b1)) u_e (
      .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(ir[4]), .in1(in1), .in2(in2),
      .in_last(in_last), .out_valid(ov[4]), .out_ready(out_ready), .out(o_e), .ovf(of[4]));

   task automatic chk(input string nm, input int idx, input longint act, input longint exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s[%0d] got %0h expected %0h (cycle %0d)", nm, idx, act, exp, cyc);
   endtask

   // Dot product of the collected pairs using exact integer arithmetic; a 20-bit
   // accumulator (8+8+4) wraps and flags overflow, then the output range rule applies.
   function automatic longint model(input bit s1, input bit s2, input bit os, input int op,
                                    input bit sat, output bit f);
      longint acc, a, b, lo, hi, m, omax, omin;
      acc = 0;
      f = 1'b0;
      m = 64'sd1 <<< 20;
      lo = (s1 | s2) ? -(m / 2) : 0;
      hi = lo + m - 1;
      foreach (qa[i]) begin
         if (s1) a = longint'($signed(qa[i])); else a = longint'(qa[i]);
         if (s2) b = longint'($signed(qb[i])); else b = longint'(qb[i]);
         acc += a * b;
         if (acc < lo || acc > hi) begin
            f = 1'b1;
            acc = ((acc - lo) % m + m) % m + lo;
         end
      end
      omax = os ? (64'sd1 <<< (op - 1)) - 1 : (64'sd1 <<< op) - 1;
      omin = os ? -omax - 1 : 0;
      if (op < 20) begin
         if (acc > omax || acc < omin) f = 1'b1;
         if (sat) acc = (acc > omax) ? omax : (acc < omin) ? omin : acc;
      end
      return acc & ((64'sd1 <<< op) - 1);
   endfunction

   task automatic push_exp();
      exp_t e;
      bit   f;
      e.o[0] = model(1'b1, 1'b1, 1'b1, 16, 1'b1, f); e.f[0] = f;
      e.o[1] = model(1'b1, 1'b1, 1'b1, 8,  1'b1, f); e.f[1] = f;
      e.o[2] = model(1'b1, 1'b1, 1'b1, 8,  1'b0, f); e.f[2] = f;
      e.o[3] = model(1'b0, 1'b1, 1'b1, 16, 1'b1, f); e.f[3] = f;
      e.o[4] = model(1'b0, 1'b0, 1'b0, 24, 1'b1, f); e.f[4] = f;
      e.cyc = cyc + 2;
      sb.push_back(e);
      qa.delete();
      qb.delete();
   endtask

   // Called just after a rising edge: check in_ready, drive the next cycle's inputs
   // and advance the abstract flow state (0 accepting, 1 last in flight, 2 holding result).
   task automatic step(input bit v, input logic [7:0] a, input logic [7:0] b, input bit l,
                       input bit ordy);
      for (int i = 0; i < 5; i++) chk("in_ready", i, longint'(ir[i]), longint'(phase == 0));
      in_valid = v; in1 = a; in2 = b; in_last = l; out_ready = ordy;
      if (phase == 0 && v) begin
         qa.push_back(a);
         qb.push_back(b);
         if (l) begin
            push_exp();
            phase = 1;
         end
      end else if (phase == 1) phase = 2;
      else if (phase == 2 && ordy) phase = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      sb.delete(); qa.delete(); qb.delete();
      phase = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic drain();
      repeat (3) step(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
   endtask

   always @(negedge clk) begin
      logic [4:0][63:0] ao;
      exp_t             cur;
      logic             ev;
      if (!rst) begin
         ao[0] = 64'(o_a); ao[1] = 64'(o_b); ao[2] = 64'(o_c); ao[3] = 64'(o_d); ao[4] = 64'(o_e);
         if (sb.size() != 0) cur = sb[0]; else cur = '0;
         ev = (sb.size() != 0) && (cyc >= cur.cyc);
         for (int i = 0; i < 5; i++) begin
            chk("out_valid", i, longint'(ov[i]), longint'(ev));
            chk("out", i, longint'(ao[i]), ev ? longint'(cur.o[i]) : 64'sd0);
            chk("ovf", i, longint'(of[i]), ev ? longint'(cur.f[i]) : 64'sd0);
         end
         if (ev && out_ready) void'(sb.pop_front());
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
      step(1'b1, 8'd2, 8'd3, 1'b0, 1'b0);
      step(1'b1, 8'hFC, 8'd5, 1'b0, 1'b0);
      step(1'b1, 8'd7, 8'd1, 1'b1, 1'b0);
      repeat (6) step(1'b1, 8'd9, 8'd9, 1'b0, 1'b0);
      step(1'b1, 8'd9, 8'd9, 1'b0, 1'b1);
      step(1'b1, 8'd1, 8'd2, 1'b1, 1'b1);
      drain();
      step(1'b1, 8'd127, 8'd127, 1'b1, 1'b0);
      drain();
      step(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);
      drain();
      step(1'b1, 8'd5, 8'd6, 1'b0, 1'b1);
      step(1'b1, 8'd7, 8'd8, 1'b0, 1'b1);
      do_reset();
      step(1'b1, 8'd1, 8'd1, 1'b1, 1'b1);
      drain();
      step(1'b1, 8'd3, 8'd3, 1'b1, 1'b0);
      repeat (2) step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
      do_reset();
      step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
      repeat (400)
         step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
              $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
      repeat (8) step(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
      chk("scoreboard_empty", 0, longint'(sb.size()), 64'sd0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
